// File: rtl/lock_sequencer_if.sv
// Signal bundle between the transit sequencer and the canal lock controller.
// The sequencer uses the master view and the lock, or a model of it, uses the slave view.
interface lock_sequencer_if;
    logic [7:0] outer_water;
    logic [7:0] inner_water;
    logic [7:0] lock_water;
    logic       outer_closed;
    logic       inner_closed;
    logic       gondola_arr;
    logic       gondola_dep;
    logic       cmd_arrive;
    logic       cmd_depart;
    logic       cmd_outer_cl;
    logic       cmd_inner_cl;
    logic       cmd_raise;
    logic       cmd_lower;
    logic       cmd_dir;

    modport master (
        input  outer_water, inner_water, lock_water,
        input  outer_closed, inner_closed, gondola_arr, gondola_dep,
        output cmd_arrive, cmd_depart, cmd_outer_cl, cmd_inner_cl,
        output cmd_raise, cmd_lower, cmd_dir
    );

    modport slave (
        output outer_water, inner_water, lock_water,
        output outer_closed, inner_closed, gondola_arr, gondola_dep,
        input  cmd_arrive, cmd_depart, cmd_outer_cl, cmd_inner_cl,
        input  cmd_raise, cmd_lower, cmd_dir
    );
endinterface

// File: rtl/lock_sequencer.sv
// Autonomous canal-lock transit sequencer: one full gondola transit per accepted request.
// Optional wait-state watchdog is enabled by defining LOCK_SEQ_TIMEOUT_EN.
module lock_sequencer #(
    parameter int TOL       = 1,
    parameter int ENTER_CYC = 4
`ifdef LOCK_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    // i_req is sampled only in IDLE and is accepted on that edge; o_busy high means
    // further requests are dropped, not queued. o_done pulses once per finished transit.
    input  logic             i_req,
    input  logic             i_dir,
    lock_sequencer_if.master lk,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault,
    output logic [3:0]       o_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARRIVE, S_ARR_WAIT, S_ALIGN_IN, S_OPEN_IN, S_ENTER,
        S_CLOSE_IN, S_ALIGN_OUT, S_OPEN_OUT, S_EXIT, S_CLOSE_OUT, S_FAULT
    } state_t;

    localparam int         CW   = (ENTER_CYC > 1) ? $clog2(ENTER_CYC) : 1;
    localparam logic [8:0] TOL9 = 9'(TOL);

    state_t          r_state, w_state;
    logic            r_dir, w_dir;
    logic            r_settle, w_settle;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_dep_seen, w_dep_seen;
    logic            r_arrive, w_arrive;
    logic            r_depart, w_depart;
    logic            r_outer_cl, w_outer_cl;
    logic            r_inner_cl, w_inner_cl;
    logic            r_raise, w_raise;
    logic            r_lower, w_lower;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            w_entry_open, w_exit_open;
    logic            w_entry_closed, w_exit_closed;
    logic [7:0]      w_entry_tgt, w_exit_tgt;
    logic [8:0]      w_tgt9, w_lvl9;
    logic            w_low, w_high;

    // Entry side is the outer port when r_dir=1; the exit side is always the other one.
    assign w_entry_closed = r_dir ? lk.outer_closed : lk.inner_closed;
    assign w_exit_closed  = r_dir ? lk.inner_closed : lk.outer_closed;
    assign w_entry_tgt    = r_dir ? lk.outer_water  : lk.inner_water;
    assign w_exit_tgt     = r_dir ? lk.inner_water  : lk.outer_water;

    // 9-bit compare so neither lvl+TOL nor tgt+TOL can wrap at 255.
    assign w_tgt9 = {1'b0, (r_state == S_ALIGN_OUT) ? w_exit_tgt : w_entry_tgt};
    assign w_lvl9 = {1'b0, lk.lock_water};
    assign w_low  = (w_lvl9 + TOL9) < w_tgt9;
    assign w_high = w_lvl9 > (w_tgt9 + TOL9);

`ifdef LOCK_SEQ_TIMEOUT_EN
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WW-1:0] r_wait, w_wait;
    logic          r_fault;
`endif

    always_comb begin
        w_state    = r_state;
        w_dir      = r_dir;
        w_settle   = 1'b0;
        w_cnt      = '0;
        w_dep_seen = 1'b0;
        w_raise    = 1'b0;
        w_lower    = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_dir   = i_dir;
                    w_state = S_ARRIVE;
                end
            end
            S_ARRIVE:   if (lk.gondola_arr)  w_state = S_ARR_WAIT;
            S_ARR_WAIT: if (!lk.gondola_arr) w_state = S_ALIGN_IN;
            S_ALIGN_IN, S_ALIGN_OUT: begin
                // ISSUE cycle when r_settle=0; the following SETTLE cycle lets the level update.
                if (!r_settle) begin
                    if (w_low) begin
                        w_raise  = 1'b1;
                        w_settle = 1'b1;
                    end else if (w_high) begin
                        w_lower  = 1'b1;
                        w_settle = 1'b1;
                    end else begin
                        w_state = (r_state == S_ALIGN_IN) ? S_OPEN_IN : S_OPEN_OUT;
                    end
                end
            end
            S_OPEN_IN: if (!w_entry_closed) w_state = S_ENTER;
            S_ENTER: begin
                if (r_cnt == CW'(ENTER_CYC - 1)) w_state = S_CLOSE_IN;
                else                             w_cnt   = r_cnt + 1'b1;
            end
            S_CLOSE_IN: if (w_entry_closed) w_state = S_ALIGN_OUT;
            S_OPEN_OUT: if (!w_exit_closed) w_state = S_EXIT;
            S_EXIT: begin
                w_dep_seen = r_dep_seen | lk.gondola_dep;
                if (r_dep_seen && !lk.gondola_dep) begin
                    w_dep_seen = 1'b0;
                    w_state    = S_CLOSE_OUT;
                end
            end
            S_CLOSE_OUT: begin
                if (w_exit_closed) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end
            end
            default: ;
        endcase

`ifdef LOCK_SEQ_TIMEOUT_EN
        // Watchdog: counts cycles spent in the same wait state; any state change clears it.
        w_wait = '0;
        if (w_state == r_state && r_state != S_IDLE && r_state != S_ENTER && r_state != S_FAULT) begin
            if (r_wait == WW'(TIMEOUT - 1)) begin
                w_state = S_FAULT;
                w_raise = 1'b0;
                w_lower = 1'b0;
            end else begin
                w_wait = r_wait + 1'b1;
            end
        end
`endif

        // Registered outputs are decoded from the next state so they line up with it.
        w_entry_open = (w_state == S_OPEN_IN)  || (w_state == S_ENTER);
        w_exit_open  = (w_state == S_OPEN_OUT) || (w_state == S_EXIT);
        w_outer_cl   = w_dir ? !w_entry_open : !w_exit_open;
        w_inner_cl   = w_dir ? !w_exit_open  : !w_entry_open;
        w_arrive     = (w_state == S_ARRIVE) || (w_state == S_ARR_WAIT);
        w_depart     = (w_state == S_EXIT);
        w_busy       = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_settle   <= 1'b0;
            r_cnt      <= '0;
            r_dep_seen <= 1'b0;
            r_arrive   <= 1'b0;
            r_depart   <= 1'b0;
            r_outer_cl <= 1'b1;
            r_inner_cl <= 1'b1;
            r_raise    <= 1'b0;
            r_lower    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_dir      <= w_dir;
            r_settle   <= w_settle;
            r_cnt      <= w_cnt;
            r_dep_seen <= w_dep_seen;
            r_arrive   <= w_arrive;
            r_depart   <= w_depart;
            r_outer_cl <= w_outer_cl;
            r_inner_cl <= w_inner_cl;
            r_raise    <= w_raise;
            r_lower    <= w_lower;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

`ifdef LOCK_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_wait  <= w_wait;
            r_fault <= (w_state == S_FAULT);
        end
    end
    assign o_fault = r_fault;
`else
    assign o_fault = 1'b0;
`endif

    assign lk.cmd_arrive   = r_arrive;
    assign lk.cmd_depart   = r_depart;
    assign lk.cmd_outer_cl = r_outer_cl;
    assign lk.cmd_inner_cl = r_inner_cl;
    assign lk.cmd_raise    = r_raise;
    assign lk.cmd_lower    = r_lower;
    assign lk.cmd_dir      = r_dir;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_state         = r_state;

endmodule
